// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_if
//  Description : Digit inputs, blink control and multiplexed display outputs
//                of the 7-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic [6:0] d5;          // hour tens
    logic [6:0] d4;          // hour units
    logic [6:0] d3;          // minute tens
    logic [6:0] d2;          // minute units
    logic [6:0] d1;          // second tens
    logic [6:0] d0;          // second units
    logic [5:0] blink_mask;  // bit n = 1 makes digit n blink
    logic [6:0] seg;         // segments g..a, active-low
    logic       dp;          // decimal point, active-low
    logic [5:0] dig_sel;     // one-hot digit enable, active-low

    // Source of the digits (clock counter side)
    modport master (
        output d5, d4, d3, d2, d1, d0, blink_mask,
        input  seg, dp, dig_sel
    );

    // Display driver side
    modport slave (
        input  d5, d4, d3, d2, d1, d0, blink_mask,
        output seg, dp, dig_sel
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed six-digit 7-segment driver with frame-
//                synchronous digit capture, ghost blanking, leading-zero
//                blanking, separator decimal points and per-digit blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int         SCAN_DIV    = 50000,
    parameter int         BLANK_CYC   = 500,
    parameter int         BLINK_TICKS = 250,
    parameter int         LZ_BLANK    = 1,
    parameter logic [5:0] DP_MASK     = 6'b010100
) (
    input  wire logic        clk50,
    input  wire logic        key,
    seg_scan_driver_if.slave bus
);

    localparam int                 c_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                 c_BLK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYC);
    localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_TICKS - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'd5;
    localparam logic [6:0]         c_SEG_OFF = 7'b1111111;
    localparam logic [5:0]         c_DIG_OFF = 6'b111111;

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [5:0][6:0]    r_snap;
    logic               r_load_pend;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [5:0]         r_dig_sel;

    logic               w_tick;
    logic               w_wrap;
    logic [5:0][6:0]    w_din;
    logic [6:0]         w_cur;
    logic               w_bm;
    logic               w_dpm;
    logic [5:0]         w_onehot;
    logic [6:0]         w_dec;
    logic               w_lz;
    logic               w_blk;
    logic [6:0]         w_seg;
    logic               w_dp;
    logic [5:0]         w_dig_sel;

    assign w_tick = (r_cnt == c_CNT_MAX);
    assign w_wrap = w_tick && (r_idx == c_IDX_LAST);
    assign w_din  = {bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};

    // Prescaler, slot index, blink phase and frame-synchronous digit capture
    always_ff @(posedge clk50) begin
        if (key) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_snap      <= '0;
            r_load_pend <= 1'b1;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                if (r_blink_cnt == c_BLK_MAX) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
            // Only at frame wrap (or right after reset) so a frame never mixes old and new digits
            if (r_load_pend || w_wrap) begin
                r_snap <= w_din;
            end
            r_load_pend <= 1'b0;
        end
    end

    // Select the per-slot digit, blink bit, dp bit and digit enable
    always_comb begin
        w_cur    = c_SEG_OFF;
        w_bm     = 1'b0;
        w_dpm    = 1'b0;
        w_onehot = 6'b000000;
        case (r_idx)
            3'd0: begin w_cur = r_snap[0]; w_bm = bus.blink_mask[0]; w_dpm = DP_MASK[0]; w_onehot = 6'b000001; end
            3'd1: begin w_cur = r_snap[1]; w_bm = bus.blink_mask[1]; w_dpm = DP_MASK[1]; w_onehot = 6'b000010; end
            3'd2: begin w_cur = r_snap[2]; w_bm = bus.blink_mask[2]; w_dpm = DP_MASK[2]; w_onehot = 6'b000100; end
            3'd3: begin w_cur = r_snap[3]; w_bm = bus.blink_mask[3]; w_dpm = DP_MASK[3]; w_onehot = 6'b001000; end
            3'd4: begin w_cur = r_snap[4]; w_bm = bus.blink_mask[4]; w_dpm = DP_MASK[4]; w_onehot = 6'b010000; end
            3'd5: begin w_cur = r_snap[5]; w_bm = bus.blink_mask[5]; w_dpm = DP_MASK[5]; w_onehot = 6'b100000; end
            default: ;
        endcase
    end

    // BCD to active-low segments (g..a); out-of-range values blank the digit
    always_comb begin
        w_dec = c_SEG_OFF;
        case (w_cur)
            7'd0: w_dec = 7'b1000000;
            7'd1: w_dec = 7'b1111001;
            7'd2: w_dec = 7'b0100100;
            7'd3: w_dec = 7'b0110000;
            7'd4: w_dec = 7'b0011001;
            7'd5: w_dec = 7'b0010010;
            7'd6: w_dec = 7'b0000010;
            7'd7: w_dec = 7'b1111000;
            7'd8: w_dec = 7'b0000000;
            7'd9: w_dec = 7'b0011000;
            default: w_dec = c_SEG_OFF;
        endcase
    end

    // Blanking rules and ghost window; everything dark until the first snapshot exists
    always_comb begin
        w_lz      = (LZ_BLANK != 0) && (r_idx == c_IDX_LAST) && (w_cur == 7'd0);
        w_blk     = r_phase && w_bm;
        w_seg     = (w_lz || w_blk) ? c_SEG_OFF : w_dec;
        w_dp      = ~(w_dpm && !w_lz && !w_blk);
        w_dig_sel = (r_cnt < c_BLANK) ? c_DIG_OFF : ~w_onehot;
        if (r_load_pend) begin
            w_seg     = c_SEG_OFF;
            w_dp      = 1'b1;
            w_dig_sel = c_DIG_OFF;
        end
    end

    // Registered outputs, one cycle behind the scan state
    always_ff @(posedge clk50) begin
        if (key) begin
            r_seg     <= c_SEG_OFF;
            r_dp      <= 1'b1;
            r_dig_sel <= c_DIG_OFF;
        end else begin
            r_seg     <= w_seg;
            r_dp      <= w_dp;
            r_dig_sel <= w_dig_sel;
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dp      = r_dp;
    assign bus.dig_sel = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Directed bench for seg_scan_driver (SCAN_DIV=4, BLANK_CYC=1,
//                BLINK_TICKS=3); one instance without and one with
//                leading-zero blanking, fed the same digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    typedef struct packed {
        logic [5:0][6:0] d;    // d[n] = digit input n
        logic [5:0][6:0] seg;  // expected segments in slot n, LZ_BLANK=0
        logic [6:0]      lz5;  // expected slot-5 segments, LZ_BLANK=1
    } vec_t;

    localparam logic [5:0] c_EDP = 6'b101011;  // dp low in slots 2 and 4

    logic clk50 = 1'b0;
    logic key   = 1'b1;
    int   k     = -1;      // cycles since the release edge, as seen at negedge
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [4];

    seg_scan_driver_if if0 ();
    seg_scan_driver_if if1 ();

    assign if1.d5 = if0.d5;
    assign if1.d4 = if0.d4;
    assign if1.d3 = if0.d3;
    assign if1.d2 = if0.d2;
    assign if1.d1 = if0.d1;
    assign if1.d0 = if0.d0;
    assign if1.blink_mask = if0.blink_mask;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_TICKS(3), .LZ_BLANK(0), .DP_MASK(6'b010100))
        u_dut0 (.clk50(clk50), .key(key), .bus(if0));
    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_TICKS(3), .LZ_BLANK(1), .DP_MASK(6'b010100))
        u_dut1 (.clk50(clk50), .key(key), .bus(if1));

    always #5 clk50 = ~clk50;

    // Reference cycle position
    always @(posedge clk50) k <= key ? -1 : k + 1;

    task automatic chk(input string nm, input int c, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d c=%0d: got %b, want %b", nm, k, c, act, exp);
        end
    endtask

    task automatic chk_off(input string nm);
        chk({nm, "_seg"}, -1, if0.seg, 7'b1111111);
        chk({nm, "_dp"}, -1, {6'd0, if0.dp}, 7'd1);
        chk({nm, "_dig"}, -1, {1'b0, if0.dig_sel}, 7'b0111111);
        chk({nm, "_lzseg"}, -1, if1.seg, 7'b1111111);
    endtask

    task automatic set_digits(input logic [5:0][6:0] v);
        if0.d0 = v[0]; if0.d1 = v[1]; if0.d2 = v[2];
        if0.d3 = v[3]; if0.d4 = v[4]; if0.d5 = v[5];
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while ((k < 0 || (k % 24) != 0) && n < 200);
        n_tests++;
        if (k < 0 || (k % 24) != 0) begin
            n_fail++;
            $display("FAIL frame_start_timeout: k=%0d, want multiple of 24", k);
        end
    endtask

    // Compare cycles c0..23 of a frame; caller is positioned at cycle c0
    task automatic check_frame(input logic [5:0][6:0] es, input logic [5:0] edp,
                               input logic [6:0] lz5, input int c0);
        int s;
        logic [5:0] dig;
        for (int c = c0; c < 24; c++) begin
            if (c != c0) @(negedge clk50);
            s   = c / 4;
            dig = ((c % 4) == 0) ? 6'b111111 : ~(6'b000001 << s);
            chk("seg", c, if0.seg, es[s]);
            chk("dp", c, {6'd0, if0.dp}, {6'd0, edp[s]});
            chk("dig_sel", c, {1'b0, if0.dig_sel}, {1'b0, dig});
            chk("lz_seg", c, if1.seg, (s == 5) ? lz5 : es[s]);
            chk("lz_dig_sel", c, {1'b0, if1.dig_sel}, {1'b0, dig});
        end
    endtask

    initial begin
        logic [5:0][6:0] es_t;

        vecs[0] = '{d:   {7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6},
                    seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010},
                    lz5: 7'b1111001};
        vecs[1] = '{d:   {7'd7, 7'd8, 7'd9, 7'd0, 7'd1, 7'd2},
                    seg: {7'b1111000, 7'b0000000, 7'b0011000, 7'b1000000, 7'b1111001, 7'b0100100},
                    lz5: 7'b1111000};
        vecs[2] = '{d:   {7'd0, 7'd9, 7'd5, 7'd9, 7'd12, 7'd3},
                    seg: {7'b1000000, 7'b0011000, 7'b0010010, 7'b0011000, 7'b1111111, 7'b0110000},
                    lz5: 7'b1111111};
        vecs[3] = '{d:   {7'd0, 7'd0, 7'd10, 7'd127, 7'd8, 7'd0},
                    seg: {7'b1000000, 7'b1000000, 7'b1111111, 7'b1111111, 7'b0000000, 7'b1000000},
                    lz5: 7'b1111111};

        // Reset held for two edges with arbitrary digits
        key = 1'b1;
        set_digits(vecs[3].d);
        if0.blink_mask = 6'b000000;
        @(negedge clk50); chk_off("rst1");
        @(negedge clk50); chk_off("rst2");

        // Release; snapshot is taken on the first non-reset edge
        key = 1'b0;
        set_digits(vecs[0].d);
        @(negedge clk50); chk_off("post_rst");
        @(negedge clk50);
        check_frame(vecs[0].seg, c_EDP, vecs[0].lz5, 1);

        // Table-driven patterns, each shown from the frame after capture
        for (int i = 1; i < 4; i++) begin
            set_digits(vecs[i].d);
            wait_frame_start();
            wait_frame_start();
            check_frame(vecs[i].seg, c_EDP, vecs[i].lz5, 0);
        end

        // Tearing: digits changed during slot 2 must not reach the current frame
        set_digits(vecs[0].d);
        wait_frame_start();
        wait_frame_start();
        repeat (9) @(negedge clk50);
        if0.d0 = 7'd7;
        if0.d5 = 7'd9;
        check_frame(vecs[0].seg, c_EDP, vecs[0].lz5, 9);
        es_t    = vecs[0].seg;
        es_t[0] = 7'b1111000;
        es_t[5] = 7'b0011000;
        wait_frame_start();
        check_frame(es_t, c_EDP, 7'b0011000, 0);

        // Blink: phase is 0 in slots 0-2 and 1 in slots 3-5 of every frame
        set_digits(vecs[0].d);
        if0.blink_mask = 6'b011011;
        wait_frame_start();
        wait_frame_start();
        es_t    = vecs[0].seg;
        es_t[3] = 7'b1111111;
        es_t[4] = 7'b1111111;
        check_frame(es_t, 6'b111011, vecs[0].lz5, 0);
        wait_frame_start();
        check_frame(es_t, 6'b111011, vecs[0].lz5, 0);
        if0.blink_mask = 6'b000000;

        // Mid-frame reset during slot 3
        wait_frame_start();
        repeat (13) @(negedge clk50);
        key = 1'b1;
        set_digits(vecs[1].d);
        @(negedge clk50); chk_off("mid_rst");
        key = 1'b0;
        @(negedge clk50); chk_off("mid_post_rst");
        set_digits(vecs[2].d);
        @(negedge clk50);
        check_frame(vecs[1].seg, c_EDP, vecs[1].lz5, 1);
        wait_frame_start();
        check_frame(vecs[2].seg, c_EDP, vecs[2].lz5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, k=%0d", k);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
